// File: rtl/mem_lut_pkg.sv
// ============================================================================
// Module : mem_lut_pkg
// Brief  : Shared constants, FSM state type and default table contents for
//          the data-memory address LUT.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_lut_pkg;

    localparam int IDX_W  = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Power-on contents that the table is loaded with after every reset.
    function automatic logic [DATA_W-1:0] default_entry(input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] v;
        v = '0;
        if (idx <= IDX_W'(20)) begin
            v = DATA_W'(60) + DATA_W'(idx);
        end else if (idx == IDX_W'(30)) begin
            v = DATA_W'(31);
        end else if (idx == IDX_W'(31)) begin
            v = DATA_W'(32);
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lut_rr_arb.sv
// ============================================================================
// Module : mem_lut_rr_arb
// Brief  : Two-way round-robin arbiter; bit 0 = requester A, bit 1 = B.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_lut_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Set when B was the most recent winner, so A wins the first tie.
    logic last_b_q;
    logic last_b_d;

    always_comb begin
        gnt      = 2'b00;
        last_b_d = last_b_q;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_b_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
            if (|gnt) begin
                last_b_d = gnt[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_lut_arbiter.sv
// ============================================================================
// Module : mem_lut_arbiter
// Brief  : Register-based 32x8 address table with default load and a single
//          access slot shared by cfg writes and two round-robin readers.
//          Optional macro MEM_LUT_STALL_CNT_EN adds a saturating stall counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_lut_arbiter #(
    parameter int IDX_W  = mem_lut_pkg::IDX_W,
    parameter int DATA_W = mem_lut_pkg::DATA_W,
    parameter int DEPTH  = mem_lut_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic [IDX_W-1:0]  a_idx,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic [IDX_W-1:0]  b_idx,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              cfg_ack,
`ifdef MEM_LUT_STALL_CNT_EN
    output logic [7:0]        stall_cnt,
`endif
    output logic              init_busy
);

    import mem_lut_pkg::*;

    state_e             state_q;
    state_e             state_d;
    logic [IDX_W:0]     cnt_q;
    logic [IDX_W:0]     cnt_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic               run;
    logic [1:0]         gnt;
    logic               tbl_we;
    logic [IDX_W-1:0]   tbl_waddr;
    logic [DATA_W-1:0]  tbl_wdata;
    logic               a_rvalid_q;
    logic               b_rvalid_q;
    logic [DATA_W-1:0]  a_rdata_q;
    logic [DATA_W-1:0]  b_rdata_q;

    assign run       = (state_q == ST_RUN);
    assign cfg_ack   = run && cfg_we;
    assign init_busy = (state_q == ST_INIT);
    assign a_gnt     = gnt[0];
    assign b_gnt     = gnt[1];

    mem_lut_rr_arb u_rr_arb (
        .clk   (clk),
        .reset (reset),
        .en    (run && !cfg_we),
        .req   ({b_req, a_req}),
        .gnt   (gnt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + (IDX_W+1)'(1);
                if (cnt_q == (IDX_W+1)'(DEPTH-1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Default load and cfg writes share the single write port; never both at once.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = cfg_idx;
        tbl_wdata = cfg_data;
        if (!reset) begin
            if (state_q == ST_INIT) begin
                tbl_we    = 1'b1;
                tbl_waddr = cnt_q[IDX_W-1:0];
                tbl_wdata = default_entry(cnt_q[IDX_W-1:0]);
            end else if (cfg_we) begin
                tbl_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            mem_q[tbl_waddr] <= tbl_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= gnt[0];
            b_rvalid_q <= gnt[1];
            if (gnt[0]) begin
                a_rdata_q <= mem_q[a_idx];
            end
            if (gnt[1]) begin
                b_rdata_q <= mem_q[b_idx];
            end
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

`ifdef MEM_LUT_STALL_CNT_EN
    logic [7:0] stall_cnt_q;
    logic       stall_ev;

    assign stall_ev = run && ((a_req && !gnt[0]) || (b_req && !gnt[1]));

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall_ev && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_q <= stall_cnt_q + 8'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_lut_arbiter.sv
// ============================================================================
// Module : tb_mem_lut_arbiter
// Brief  : Scoreboard bench for mem_lut_arbiter (directed vectors).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_lut_arbiter;

    logic       clk;
    logic       reset;
    logic       a_req, b_req, cfg_we;
    logic [4:0] a_idx, b_idx, cfg_idx;
    logic [7:0] cfg_data;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid, cfg_ack, init_busy;
    logic [7:0] a_rdata, b_rdata;
`ifdef MEM_LUT_STALL_CNT_EN
    logic [7:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    mem_lut_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .a_req     (a_req),
        .a_idx     (a_idx),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_idx     (b_idx),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_data  (cfg_data),
        .cfg_ack   (cfg_ack),
`ifdef MEM_LUT_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected read data whenever a response pulse appears.
    always @(negedge clk) begin
        if (a_rvalid === 1'b1) begin
            if (qa.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL a_rvalid_unexpected: got 1 expected 0");
            end else begin
                chk("a_rdata", {24'd0, a_rdata}, {24'd0, qa.pop_front()});
            end
        end
        if (b_rvalid === 1'b1) begin
            if (qb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_rvalid_unexpected: got 1 expected 0");
            end else begin
                chk("b_rdata", {24'd0, b_rdata}, {24'd0, qb.pop_front()});
            end
        end
    end

    // Hold a request until granted (bounded), push the expected data on grant.
    task automatic read_x(input bit sel, input logic [4:0] idx, input logic [7:0] exp,
                          input int exp_wait);
        int  w    = 0;
        int  busy = 0;
        bit  got  = 0;
        if (sel) begin b_idx = idx; b_req = 1'b1; end
        else     begin a_idx = idx; a_req = 1'b1; end
        while (!got && w < 100) begin
            @(negedge clk);
            if (sel ? b_gnt : a_gnt) begin
                got = 1'b1;
                if (sel) qb.push_back(exp); else qa.push_back(exp);
            end else begin
                w++;
                if (init_busy) busy++;
            end
        end
        @(posedge clk); #1;
        a_req = 1'b0; b_req = 1'b0;
        chk(sel ? "b_granted" : "a_granted", {31'd0, got}, 32'd1);
        if (exp_wait >= 0) begin
            chk("grant_wait", w, exp_wait);
            chk("init_busy_cycles", busy, exp_wait);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; a_req = 0; b_req = 0; cfg_we = 0;
        a_idx = 0; b_idx = 0; cfg_idx = 0; cfg_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_init_busy", {31'd0, init_busy}, 32'd1);
        chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
        chk("rst_a_rdata", {24'd0, a_rdata}, 32'd0);
        chk("rst_b_rdata", {24'd0, b_rdata}, 32'd0);
        chk("rst_cfg_ack", {31'd0, cfg_ack}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // A holds idx 5 through the whole 32-cycle default load.
        read_x(1'b0, 5'd5, 8'd65, 32);
        chk("run_init_busy", {31'd0, init_busy}, 32'd0);

        read_x(1'b1, 5'd31, 8'd32, 0);
        read_x(1'b1, 5'd30, 8'd31, 0);
        read_x(1'b1, 5'd25, 8'd0, 0);

        // Both requesters held: last winner was B, so A, B, A, B.
        a_idx = 5'd0; b_idx = 5'd20; a_req = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("alt_a_gnt", {31'd0, a_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("alt_b_gnt", {31'd0, b_gnt}, (i % 2 == 0) ? 32'd0 : 32'd1);
            if (a_gnt) qa.push_back(8'd60);
            if (b_gnt) qb.push_back(8'd80);
            @(posedge clk); #1;
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Config write collides with a read of the same index.
        cfg_we = 1'b1; cfg_idx = 5'd3; cfg_data = 8'hAA;
        a_idx = 5'd3; a_req = 1'b1;
        @(negedge clk);
        chk("cfg_ack", {31'd0, cfg_ack}, 32'd1);
        chk("cfg_a_gnt_blocked", {31'd0, a_gnt}, 32'd0);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(negedge clk);
        chk("raw_a_gnt", {31'd0, a_gnt}, 32'd1);
        chk("raw_cfg_ack_low", {31'd0, cfg_ack}, 32'd0);
        if (a_gnt) qa.push_back(8'hAA);
        @(posedge clk); #1;
        a_req = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset lands on a grant cycle: response must be dropped, table reloaded.
        a_idx = 5'd3; a_req = 1'b1;
        @(negedge clk);
        chk("pre_rst_a_gnt", {31'd0, a_gnt}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_drop_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rst_again_init_busy", {31'd0, init_busy}, 32'd1);
        read_x(1'b0, 5'd3, 8'd63, 31);

`ifdef MEM_LUT_STALL_CNT_EN
        chk("stall_single_req", {24'd0, stall_cnt}, 32'd0);
        a_idx = 5'd0; b_idx = 5'd20; a_req = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_gnt) qa.push_back(8'd60);
            if (b_gnt) qb.push_back(8'd80);
            @(posedge clk); #1;
        end
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        chk("stall_saturated", {24'd0, stall_cnt}, 32'd255);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
